seq_control: RTL and testbench
==============================

Name: seq_control

Overview:
- Parametrised run controller for multi-cycle sequential datapaths, e.g. shift-add multipliers and serial dividers.
- Detects a start-button press and release, then pulses a datapath synchronous clear and runs a cycle counter of programmable length.
- Advances only while enabled; signals first/last cycle and completion.
- Sits between the debounced start input and the datapath registers.

Parameters:
- MAX_LEN, 32: maximum run length in counted cycles; must be ≥ 1.
- START_ON_RELEASE, 1: 1 = run launches on the start falling edge (press-then-release); 0 = run launches on the rising edge.
- NBITS, CeilLog2(MAX_LEN+1): width of the length and count fields. Derived; do not override.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start request; level, already debounced and synchronised.
- enable  in  1  count-advance qualifier; 0 pauses the run.
- abort  in  1  synchronous cancel of any active run.
- len  in  NBITS  requested run length, sampled in LOAD.
- sync_reset  out  1  one-cycle datapath clear, asserted in LOAD.
- busy  out  1  high in LOAD, RUN and DONE.
- run  out  1  high in RUN (successor of the old single shot).
- done  out  1  one-cycle pulse in DONE.
- flag_first  out  1  run && count==0.
- flag_last  out  1  run && count==len_q-1.
- count  out  NBITS  current cycle index.

Behaviour:
- Reset (async, active-low): state=IDLE; count, len_q and all outputs = 0.
- States: IDLE, ARMED, LOAD, RUN, DONE (shared enum).
- IDLE:
  - START_ON_RELEASE=1: start=1 → ARMED.
  - START_ON_RELEASE=0: start=1 → LOAD (rising edge only; start must have been 0 in the previous cycle).
- ARMED: start=0 → LOAD; otherwise hold. Outputs all low.
- LOAD (exactly 1 cycle):
  - sync_reset=1, count←0.
  - len_q←clamp(len): 0→1, >MAX_LEN→MAX_LEN.
  - Next state RUN.
- RUN:
  - enable=1: if count==len_q-1 then count←0 and → DONE, else count←count+1.
  - enable=0: count and state hold; run stays 1.
- DONE (exactly 1 cycle): done=1, then → IDLE.
- start while busy:
  - Ignored in LOAD, RUN and DONE.
  - With START_ON_RELEASE=0, a start still high after DONE does not relaunch; it must drop to 0 first (edge detect register).
- abort=1 in ARMED, LOAD, RUN or DONE → IDLE next cycle.
  - count←0; done not pulsed.
  - abort has priority over every other transition, including enable-driven completion.
- Latency:
  - Rising edge of start (mode 0): 1 cycle to sync_reset.
  - Falling edge of start (mode 1): 1 cycle to sync_reset.
  - With enable held high, done arrives len_q+1 cycles after sync_reset.
- len changes during RUN have no effect (len_q is latched).
- flag_first and flag_last are both high in the single RUN cycle when len_q==1.
- All outputs are decoded combinationally from state and count; registered state only, no output glitch requirement beyond that.
- Unused state encodings → IDLE.

Optional Feature:
- Macro: SEQ_CTRL_AUTO_REPEAT_EN.
- Defined: DONE → LOAD instead of IDLE. The block relaunches continuously, re-sampling len each LOAD, until abort=1 (→ IDLE).
  - done still pulses once per run.
  - busy stays high between runs.
- Undefined: DONE → IDLE; each run needs a new start edge.

Decomposition:
- Package seq_control_pkg holds:
  - the state enum typedef;
  - the CeilLog2 function;
  - a clamp_len function.
- One natural sub-module: seq_counter, a parametrised enabled up-counter with sync clear, terminal-compare and wrap. It owns count and the flag decode.
- FSM and length latch stay in seq_control.

Test Plan:
- Press/release, MAX_LEN=32, len=5, enable=1:
  - start 1 for 3 cycles, then 0 → sync_reset 1 cycle later;
  - run high 5 cycles, count 0..4;
  - flag_first at count=0, flag_last at count=4;
  - done 1 cycle later, then IDLE.
- Pause: len=4, enable low for 3 cycles at count=2 → count holds at 2, run stays 1, done delayed exactly 3 cycles.
- Clamping:
  - len=0 → single RUN cycle with flag_first=flag_last=1.
  - len=40, MAX_LEN=32 → 32 RUN cycles.
- Abort at count=3 of len=8 → IDLE next cycle, count=0, no done pulse; a following start press/release launches normally.
- Async reset asserted mid-RUN (count=6) → all outputs 0 immediately; after deassertion the block waits in IDLE for start.
- START_ON_RELEASE=0 with start held high across a whole run → exactly one run, no relaunch until start toggles 0→1.
  - With SEQ_CTRL_AUTO_REPEAT_EN defined, len=3: done pulses every 5 cycles until abort.

Source files
------------

// File: rtl/seq_control_pkg.sv
// -----------------------------------------------------------------------------
// seq_control_pkg
//
// Purpose : Shared types and helpers for the seq_control run controller and
//           its counter sub-module.
//
// Contents:
//   state_t     - controller state encoding (IDLE, ARMED, LOAD, RUN, DONE).
//   ceil_log2() - smallest n with 2**n >= value; used to size the length and
//                 count fields from MAX_LEN at elaboration time.
//   clamp_len() - maps a requested run length onto the legal range
//                 1..max_len (0 becomes 1, anything above max_len saturates).
// -----------------------------------------------------------------------------
package seq_control_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_LOAD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Elaboration-time width helper. The loop bound keeps it a plain constant
   // function that every tool can evaluate.
   function automatic int ceil_log2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // A run always lasts at least one counted cycle and never more than the
   // counter can represent as a terminal index.
   function automatic int clamp_len(input int req_len, input int max_len);
      int result;
      if (req_len < 1) begin
         result = 1;
      end else if (req_len > max_len) begin
         result = max_len;
      end else begin
         result = req_len;
      end
      return result;
   endfunction

endpackage : seq_control_pkg

// File: rtl/seq_counter.sv
// -----------------------------------------------------------------------------
// seq_counter
//
// Purpose : Enabled up-counter with synchronous clear, terminal compare and
//           wrap-to-zero. Also decodes the first/last-cycle flags so the
//           controller only has to say whether the count is currently live.
//
// Parameters:
//   NBITS      - counter width.
//
// Ports:
//   clk        in   clock.
//   reset      in   asynchronous, active-low reset (count -> 0).
//   i_clear    in   synchronous clear; wins over i_advance.
//   i_advance  in   step the counter this cycle (wraps to 0 at terminal).
//   i_active   in   qualifies the flag outputs (count is meaningful).
//   i_term     in   terminal index (last value before wrap).
//   o_count    out  current count.
//   o_at_term  out  count equals i_term (unqualified, for the controller).
//   o_first    out  i_active && count == 0.
//   o_last     out  i_active && count == i_term.
// -----------------------------------------------------------------------------
module seq_counter #(
   parameter int NBITS = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_advance,
   input  logic             i_active,
   input  logic [NBITS-1:0] i_term,
   output logic [NBITS-1:0] o_count,
   output logic             o_at_term,
   output logic             o_first,
   output logic             o_last
);

   logic [NBITS-1:0] r_count;
   logic             w_at_term;

   assign w_at_term = (r_count == i_term);

   // NOTE: clocked state uses non-blocking (<=) so every register samples the
   // pre-edge values of the others, independent of block evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_advance) begin
         r_count <= w_at_term ? '0 : r_count + 1'b1;
      end
   end

   assign o_count   = r_count;
   assign o_at_term = w_at_term;
   assign o_first   = i_active && (r_count == '0);
   assign o_last    = i_active && w_at_term;

endmodule : seq_counter

// File: rtl/seq_control.sv
// -----------------------------------------------------------------------------
// seq_control
//
// Purpose : Run controller for multi-cycle sequential datapaths (shift-add
//           multipliers, serial dividers, ...). Detects a start request,
//           pulses a one-cycle datapath clear, then counts a latched number
//           of cycles, advancing only while enabled, and pulses done.
//
// Parameters:
//   MAX_LEN          - maximum run length in counted cycles (>= 1).
//   START_ON_RELEASE - 1: launch on start falling edge (press then release).
//                      0: launch on start rising edge.
//   NBITS            - width of len/count; derived from MAX_LEN, do not set.
//
// Compile-time option:
//   SEQ_CTRL_AUTO_REPEAT_EN - when defined, DONE goes straight back to LOAD so
//                             runs repeat (re-sampling len) until abort.
//
// Ports:
//   clk         in   clock.
//   reset       in   asynchronous, active-low reset.
//   start       in   start request level (debounced, synchronised).
//   enable      in   count-advance qualifier; 0 pauses a run.
//   abort       in   synchronous cancel of any active run.
//   len         in   requested run length, sampled in LOAD.
//   sync_reset  out  one-cycle datapath clear (LOAD).
//   busy        out  high in LOAD, RUN and DONE.
//   run         out  high in RUN.
//   done        out  one-cycle pulse (DONE).
//   flag_first  out  run && count == 0.
//   flag_last   out  run && count == latched length - 1.
//   count       out  current cycle index.
// -----------------------------------------------------------------------------
module seq_control
   import seq_control_pkg::*;
#(
   parameter int MAX_LEN          = 32,
   parameter bit START_ON_RELEASE = 1'b1,
   parameter int NBITS            = ceil_log2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             enable,
   input  logic             abort,
   input  logic [NBITS-1:0] len,
   output logic             sync_reset,
   output logic             busy,
   output logic             run,
   output logic             done,
   output logic             flag_first,
   output logic             flag_last,
   output logic [NBITS-1:0] count
);

   state_t           r_state;
   logic [NBITS-1:0] r_len_q;
   logic             r_start_d;

   logic             w_start_rise;
   logic             w_in_load;
   logic             w_in_run;
   logic             w_clear;
   logic             w_advance;
   logic [NBITS-1:0] w_term;
   logic             w_at_term;

   // Previous start level tracked every cycle, so a start held high through a
   // whole run cannot relaunch: it has to be seen low before another rise.
   assign w_start_rise = start && !r_start_d;

   assign w_in_load = (r_state == ST_LOAD);
   assign w_in_run  = (r_state == ST_RUN);

   // Count restarts at 0 entering RUN and after a cancelled run.
   assign w_clear   = w_in_load || abort;
   assign w_advance = w_in_run && enable;

   // r_len_q is at least 1 whenever RUN is reachable, so the terminal index
   // never underflows while it matters.
   assign w_term = r_len_q - 1'b1;

   seq_counter #(
      .NBITS     (NBITS)
   ) u_counter (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_clear),
      .i_advance (w_advance),
      .i_active  (w_in_run),
      .i_term    (w_term),
      .o_count   (count),
      .o_at_term (w_at_term),
      .o_first   (flag_first),
      .o_last    (flag_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_len_q   <= '0;
         r_start_d <= 1'b0;
      end else begin
         r_start_d <= start;
         // abort outranks every transition, including enable-driven
         // completion, so a cancelled run never pulses done.
         if (abort) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (START_ON_RELEASE) begin
                     if (start) begin
                        r_state <= ST_ARMED;
                     end
                  end else if (w_start_rise) begin
                     r_state <= ST_LOAD;
                  end
               end
               ST_ARMED: begin
                  if (!start) begin
                     r_state <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  r_len_q <= NBITS'(clamp_len(int'(len), MAX_LEN));
                  r_state <= ST_RUN;
               end
               ST_RUN: begin
                  if (enable && w_at_term) begin
                     r_state <= ST_DONE;
                  end
               end
               ST_DONE: begin
`ifdef SEQ_CTRL_AUTO_REPEAT_EN
                  r_state <= ST_LOAD;
`else
                  r_state <= ST_IDLE;
`endif
               end
               // NOTE: the default arm returns any unused encoding to IDLE
               // instead of leaving the state undefined.
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign sync_reset = w_in_load;
   assign run        = w_in_run;
   assign done       = (r_state == ST_DONE);
   assign busy       = w_in_load || w_in_run || (r_state == ST_DONE);

endmodule : seq_control

// File: tb/tb_seq_control.sv
// -----------------------------------------------------------------------------
// tb_seq_control
//
// Two controllers share one set of stimulus inputs:
//   dut_a : MAX_LEN=32, launch on start release.
//   dut_b : MAX_LEN=5,  launch on start rise (len driven from the low bits).
// A position-in-run model for each is compared against every output on every
// falling clock edge; directed phases add literal expectations for latency,
// pause, clamping, abort, async reset and edge-detect behaviour, followed by
// a randomized phase.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_control;

   localparam int MAXA = 32;
   localparam int MAXB = 5;
   localparam int NA   = 6;
   localparam int NB   = 3;
`ifdef SEQ_CTRL_AUTO_REPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic          clk    = 1'b0;
   logic          reset  = 1'b1;
   logic          start  = 1'b0;
   logic          enable = 1'b0;
   logic          abort  = 1'b0;
   logic [NA-1:0] len    = '0;

   logic          a_sync_reset, a_busy, a_run, a_done, a_first, a_last;
   logic [NA-1:0] a_count;
   logic          b_sync_reset, b_busy, b_run, b_done, b_first, b_last;
   logic [NB-1:0] b_count;

   int n_total = 0;
   int n_bad   = 0;
   bit cmp_en  = 1'b0;

   always #5 clk = ~clk;

   seq_control #(.MAX_LEN(MAXA), .START_ON_RELEASE(1'b1)) dut_a (
      .clk(clk), .reset(reset), .start(start), .enable(enable), .abort(abort),
      .len(len), .sync_reset(a_sync_reset), .busy(a_busy), .run(a_run),
      .done(a_done), .flag_first(a_first), .flag_last(a_last), .count(a_count)
   );

   seq_control #(.MAX_LEN(MAXB), .START_ON_RELEASE(1'b0)) dut_b (
      .clk(clk), .reset(reset), .start(start), .enable(enable), .abort(abort),
      .len(len[NB-1:0]), .sync_reset(b_sync_reset), .busy(b_busy), .run(b_run),
      .done(b_done), .flag_first(b_first), .flag_last(b_last), .count(b_count)
   );

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Model: position within a run. -1 idle (armed tracked separately),
   // 0 = clear cycle, 1..L = counted cycles, L+1 = completion cycle.
   // ---------------------------------------------------------------------
   int m_pos   [2];
   int m_len   [2];
   bit m_armed [2];
   bit m_prev  [2];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            m_pos[d]   <= -1;
            m_len[d]   <= 0;
            m_armed[d] <= 1'b0;
            m_prev[d]  <= 1'b0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            begin : step
               int pos_n;
               int len_n;
               int req;
               int mx;
               bit armed_n;
               bit on_release;
               on_release = (d == 0);
               mx         = (d == 0) ? MAXA : MAXB;
               req        = (d == 0) ? int'(len) : int'(len[NB-1:0]);
               pos_n      = m_pos[d];
               len_n      = m_len[d];
               armed_n    = m_armed[d];
               if (m_pos[d] < 0) begin
                  if (abort) armed_n = 1'b0;
                  else if (!on_release) begin
                     if (start && !m_prev[d]) pos_n = 0;
                  end else if (!m_armed[d]) begin
                     if (start) armed_n = 1'b1;
                  end else if (!start) begin
                     armed_n = 1'b0;
                     pos_n   = 0;
                  end
               end else if (abort) begin
                  pos_n = -1;
               end else if (m_pos[d] == 0) begin
                  len_n = (req < 1) ? 1 : ((req > mx) ? mx : req);
                  pos_n = 1;
               end else if (m_pos[d] <= m_len[d]) begin
                  if (enable) pos_n = m_pos[d] + 1;
               end else begin
                  pos_n = AUTO ? 0 : -1;
               end
               m_pos[d]   <= pos_n;
               m_len[d]   <= len_n;
               m_armed[d] <= armed_n;
               m_prev[d]  <= start;
            end
         end
      end
   end

   task automatic compare(input int d, input string tag, input logic sr, input logic bsy,
                          input logic rn, input logic dn, input logic ff, input logic fl,
                          input int cnt);
      bit live;
      live = (m_pos[d] >= 1) && (m_pos[d] <= m_len[d]);
      check({tag, ".sync_reset"}, sr,  int'(m_pos[d] == 0));
      check({tag, ".busy"},       bsy, int'(m_pos[d] >= 0));
      check({tag, ".run"},        rn,  int'(live));
      check({tag, ".done"},       dn,  int'(m_pos[d] >= 2 && m_pos[d] == m_len[d] + 1));
      check({tag, ".flag_first"}, ff,  int'(live && m_pos[d] == 1));
      check({tag, ".flag_last"},  fl,  int'(live && m_pos[d] == m_len[d]));
      check({tag, ".count"},      cnt, live ? m_pos[d] - 1 : 0);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         compare(0, "a", a_sync_reset, a_busy, a_run, a_done, a_first, a_last, int'(a_count));
         compare(1, "b", b_sync_reset, b_busy, b_run, b_done, b_first, b_last, int'(b_count));
      end
   end

   // ---------------------------------------------------------------------
   // Directed helpers (observe dut_a).
   // ---------------------------------------------------------------------
   task automatic press_release(input int hold_cycles);
      @(negedge clk);
      start = 1'b1;
      repeat (hold_cycles) @(negedge clk);
      start = 1'b0;
   endtask

   // Steps up to budget falling edges (t = 1, 2, ...) recording when events
   // appear; optionally pauses enable or pulses abort at a chosen count.
   task automatic measure(input int budget, input int pause_at, input int pause_len,
                          input int abort_at, output int t_sync, output int t_done,
                          output int n_run, output int n_first, output int n_last,
                          output int last_cnt);
      int  hold;
      bit  paused;
      bit  aborted;
      hold = 0; paused = 1'b0; aborted = 1'b0;
      t_sync = -1; t_done = -1; n_run = 0; n_first = 0; n_last = 0; last_cnt = -1;
      for (int t = 1; t <= budget; t++) begin
         @(negedge clk);
         if (abort) abort = 1'b0;
         if (hold > 0) begin
            hold--;
            if (hold == 0) enable = 1'b1;
         end
         if (a_sync_reset && t_sync < 0) t_sync = t;
         if (a_run) begin
            n_run++;
            last_cnt = int'(a_count);
         end
         if (a_first) n_first++;
         if (a_last)  n_last++;
         if (a_done) begin
            t_done = t;
            break;
         end
         if (a_run && int'(a_count) == pause_at && !paused) begin
            paused = 1'b1;
            enable = 1'b0;
            hold   = pause_len;
         end
         if (a_run && int'(a_count) == abort_at && !aborted) begin
            aborted = 1'b1;
            abort   = 1'b1;
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ts, td, nr, nf, nl, lc, cnt;
      int prev_done;
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst.a_busy",  a_busy,  0);
      check("rst.a_run",   a_run,   0);
      check("rst.a_sr",    a_sync_reset, 0);
      check("rst.a_count", int'(a_count), 0);
      check("rst.b_busy",  b_busy,  0);
      reset  = 1'b1;
      cmp_en = 1'b1;
      enable = 1'b1;
      repeat (2) @(negedge clk);

`ifndef SEQ_CTRL_AUTO_REPEAT_EN
      // Press/release, len=5.
      len = 6'd5;
      press_release(3);
      measure(20, -1, 0, -1, ts, td, nr, nf, nl, lc);
      check("pr.t_sync", ts, 1);
      check("pr.n_run",  nr, 5);
      check("pr.first",  nf, 1);
      check("pr.last",   nl, 1);
      check("pr.lastcnt", lc, 4);
      check("pr.t_done", td, 7);
      @(negedge clk);
      check("pr.idle", a_busy, 0);

      // Pause three cycles at count 2, len=4.
      len = 6'd4;
      press_release(2);
      measure(30, 2, 3, -1, ts, td, nr, nf, nl, lc);
      check("pause.n_run",  nr, 7);
      check("pause.t_done", td, 9);
      check("pause.lastcnt", lc, 3);

      // len=0 clamps to one cycle with both flags.
      len = 6'd0;
      press_release(2);
      measure(20, -1, 0, -1, ts, td, nr, nf, nl, lc);
      check("len0.n_run",  nr, 1);
      check("len0.first",  nf, 1);
      check("len0.last",   nl, 1);
      check("len0.t_done", td, 3);

      // len=40 saturates at 32.
      len = 6'd40;
      press_release(2);
      measure(60, -1, 0, -1, ts, td, nr, nf, nl, lc);
      check("len40.n_run",   nr, 32);
      check("len40.lastcnt", lc, 31);
      check("len40.t_done",  td, 34);

      // Abort at count 3 of len 8, then a normal launch.
      len = 6'd8;
      press_release(2);
      measure(20, -1, 0, 3, ts, td, nr, nf, nl, lc);
      check("abort.n_run",  nr, 4);
      check("abort.t_done", td, -1);
      check("abort.idle",   a_busy, 0);
      len = 6'd5;
      press_release(2);
      measure(20, -1, 0, -1, ts, td, nr, nf, nl, lc);
      check("relaunch.t_done", td, 7);

      // Async reset mid-run at count 6.
      len = 6'd10;
      press_release(2);
      cnt = 0;
      while (!(a_run && a_count == 6'd6) && cnt < 30) begin
         @(negedge clk);
         cnt++;
      end
      check("arst.reached6", int'(a_count), 6);
      #2 reset = 1'b0;
      #1;
      check("arst.busy",  a_busy, 0);
      check("arst.run",   a_run,  0);
      check("arst.count", int'(a_count), 0);
      check("arst.flags", int'({a_first, a_last, a_done, a_sync_reset}), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("arst.waits", a_busy, 0);

      // Rising-edge mode with start held across a whole run (dut_b).
      len = 6'd3;
      nr = 0;
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (b_done) nr++;
      end
      check("hold.b_runs", nr, 1);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      nr = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (b_done) nr++;
      end
      check("retoggle.b_runs", nr, 1);
      start = 1'b0;
      repeat (10) @(negedge clk);
`else
      // Auto-repeat: len=3 gives a done pulse every 5 cycles until abort.
      len = 6'd3;
      press_release(2);
      nr = 0; prev_done = -1;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (a_done) begin
            if (prev_done >= 0) check("auto.period", t - prev_done, 5);
            prev_done = t;
            nr++;
         end
      end
      check("auto.pulses", int'(nr >= 5), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      nr = 0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (a_done || a_busy) nr++;
      end
      check("auto.stopped", nr, 0);
`endif

      // Randomized phase; the model checks every cycle.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 9) == 0) start = ~start;
         enable = ($urandom_range(0, 9) < 8);
         abort  = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 7) == 0) len = NA'($urandom_range(0, 45));
      end
      abort = 1'b0;
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_seq_control
